// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state encodings and serial line constants for the UART link
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 receiver: 2-flop synchroniser, RX FSM, bit counter, shift register
//   clk, rst      : clock, async active-high reset
//   rx_bit        : serial input, idle high
//   rx_data       : last correctly framed byte
//   rx_valid      : one-cycle pulse when rx_data updates
//   rx_frame_err  : one-cycle pulse when the stop bit is sampled low
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_bit,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 line;

  assign sync_d = {sync_q[0], rx_bit};
  assign line   = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      sync_q  <= {2{LINE_IDLE}};
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (line == START_BIT) begin
          cnt_d = '0;
          idx_d = '0;
          // With no half-bit wait the detect cycle already is the mid-bit sample.
          if (HALF_CNT == '0) begin
            state_d = RX_DATA;
          end else begin
            state_d = RX_START;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      RX_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = (line == START_BIT) ? RX_DATA : RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_BIT) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (line == STOP_BIT) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = RX_WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_WAIT_IDLE: begin
        if (line == LINE_IDLE) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - 8N1 transmitter: TX FSM, bit counter, shift register, registered line
//   clk, rst   : clock, async active-high reset
//   load       : load request, honoured only in IDLE
//   load_data  : byte latched on load
//   tx_bit     : serial output, idle high
//   tx_ready   : transmitter in IDLE
//   tx_busy    : frame in progress
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] load_data,
  output logic                 tx_bit,
  output logic                 tx_ready,
  output logic                 tx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 bit_q, bit_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      bit_q   <= LINE_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  // The line value is computed alongside the state change so it leaves a flop
  // and lines up exactly with the state it belongs to.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    case (state_q)
      TX_IDLE: begin
        bit_d = LINE_IDLE;
        if (load) begin
          shift_d = load_data;
          cnt_d   = '0;
          idx_d   = '0;
          bit_d   = START_BIT;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          bit_d   = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d = '0;
          if (idx_q == LAST_BIT) begin
            bit_d   = STOP_BIT;
            state_d = TX_STOP;
          end else begin
            bit_d   = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          bit_d   = LINE_IDLE;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign tx_bit   = bit_q;
  assign tx_ready = (state_q == TX_IDLE);
  assign tx_busy  = (state_q != TX_IDLE);

endmodule

// File: rtl/uart_serial_link.sv
// rtl/uart_serial_link.sv - full-duplex 8N1 UART link with optional receive-to-transmit echo
//   clk, rst          : clock, async active-high reset
//   rx_bit / tx_bit   : serial in / out, idle high
//   rx_data, rx_valid : received byte and its one-cycle strobe
//   rx_frame_err      : one-cycle strobe on a low stop bit
//   tx_data, tx_valid : host byte and load request (ignored when ECHO=1)
//   tx_ready, tx_busy : transmitter idle / sending
//   tx_overrun        : one-cycle strobe when an echo byte is dropped
module uart_serial_link
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8,
  parameter bit ECHO         = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_bit,
  output logic                 tx_bit,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_overrun
);

  logic                 load;
  logic [DATA_BITS-1:0] load_data;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .rx_bit      (rx_bit),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err)
  );

  assign load      = ECHO ? rx_valid : tx_valid;
  assign load_data = ECHO ? rx_data  : tx_data;

  // A received byte that finds the transmitter mid-frame is simply lost.
  assign tx_overrun = ECHO && rx_valid && !tx_ready;

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(load_data),
    .tx_bit   (tx_bit),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy)
  );

endmodule

// File: tb/tb_uart_serial_link.sv
// tb/tb_uart_serial_link.sv - self-checking bench for uart_serial_link (echo and host-driven instances)
module tb_uart_serial_link;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: one clock per bit, echo on; tx_valid held high to show it is ignored.
  logic       rx_a = 1'b1, tx_a, rv_a, fe_a, trdy_a, tbusy_a, ovr_a;
  logic [7:0] rxd_a;
  logic [7:0] txd_a = 8'h5A;
  logic       tv_a  = 1'b1;

  uart_serial_link #(.CLKS_PER_BIT(1), .DATA_BITS(8), .ECHO(1'b1)) dut_a (
    .clk(clk), .rst(rst), .rx_bit(rx_a), .tx_bit(tx_a), .rx_data(rxd_a),
    .rx_valid(rv_a), .rx_frame_err(fe_a), .tx_data(txd_a), .tx_valid(tv_a),
    .tx_ready(trdy_a), .tx_busy(tbusy_a), .tx_overrun(ovr_a));

  // Instance B: 16 clocks per bit, host-driven transmitter.
  logic       rx_b = 1'b1, tx_b, rv_b, fe_b, trdy_b, tbusy_b, ovr_b;
  logic [7:0] rxd_b;
  logic [7:0] txd_b = 8'h00;
  logic       tv_b  = 1'b0;

  uart_serial_link #(.CLKS_PER_BIT(16), .DATA_BITS(8), .ECHO(1'b0)) dut_b (
    .clk(clk), .rst(rst), .rx_bit(rx_b), .tx_bit(tx_b), .rx_data(rxd_b),
    .rx_valid(rv_b), .rx_frame_err(fe_b), .tx_data(txd_b), .tx_valid(tv_b),
    .tx_ready(trdy_b), .tx_busy(tbusy_b), .tx_overrun(ovr_b));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observation logs for instance A, filled at the falling edge.
  logic [7:0] got_rx[$];
  logic [7:0] got_tx[$];
  int rv_cyc[$];
  int txs_cyc[$];
  int busy_len[$];
  int n_fe = 0, n_ovr = 0, busy_run = 0, dec_n = 0;
  logic [7:0] dec_sh = 8'h00;
  int n_rv_b = 0, n_fe_b = 0, n_ovr_b = 0;
  int last_stop_cyc = 0;

  always @(negedge clk) begin
    if (rst) begin
      dec_n    = 0;
      busy_run = 0;
    end else begin
      if (rv_a) begin
        got_rx.push_back(rxd_a);
        rv_cyc.push_back(cyc);
      end
      if (fe_a)  n_fe++;
      if (ovr_a) n_ovr++;
      if (tbusy_a) busy_run++;
      else if (busy_run != 0) begin
        busy_len.push_back(busy_run);
        busy_run = 0;
      end
      // Plain one-sample-per-bit UART decoder on tx_a.
      if (dec_n == 0) begin
        if (tx_a == 1'b0) begin
          dec_n = 1;
          txs_cyc.push_back(cyc);
        end
      end else if (dec_n <= 8) begin
        dec_sh = {tx_a, dec_sh[7:1]};
        dec_n++;
      end else begin
        check_eq("tx_stop_bit", tx_a, 1);
        got_tx.push_back(dec_sh);
        dec_n = 0;
      end
      if (rv_b)  n_rv_b++;
      if (fe_b)  n_fe_b++;
      if (ovr_b) n_ovr_b++;
    end
  end

  task automatic clear_logs();
    got_rx.delete(); got_tx.delete(); rv_cyc.delete(); txs_cyc.delete(); busy_len.delete();
    n_fe = 0; n_ovr = 0;
  endtask

  task automatic idle_a(input int n);
    repeat (n) begin @(negedge clk); rx_a = 1'b1; end
  endtask

  task automatic send_a(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_a = f[i];
      if (i == 9) last_stop_cyc = cyc;
    end
  endtask

  task automatic send_b(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      repeat (16) @(negedge clk);
      rx_b = f[i];
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] b, r;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    logic [9:0] fr;
    int t, last_acc, rvt, gap, exp_ovr;

    repeat (3) @(negedge clk);
    check_eq("rst_tx_bit",   tx_a,    1);
    check_eq("rst_tx_ready", trdy_a,  1);
    check_eq("rst_tx_busy",  tbusy_a, 0);
    check_eq("rst_rx_valid", rv_a,    0);
    check_eq("rst_rx_data",  rxd_a,   0);
    check_eq("rst_frame_err", fe_a,   0);
    check_eq("rst_overrun",  ovr_a,   0);
    rst = 1'b0;
    idle_a(4);

    // Single valid frame and its echo.
    clear_logs();
    send_a(8'hC9, 1'b1);
    idle_a(20);
    check_eq("c9_rx_count", got_rx.size(), 1);
    check_eq("c9_rx_byte", (got_rx.size() > 0) ? got_rx[0] : 8'hxx, 8'hC9);
    check_eq("c9_rx_data", rxd_a, 8'hC9);
    check_eq("c9_frame_err", n_fe, 0);
    check_eq("c9_rx_latency", (rv_cyc.size() > 0) ? rv_cyc[0] : -1, last_stop_cyc + 3);
    check_eq("c9_tx_count", got_tx.size(), 1);
    check_eq("c9_tx_byte", (got_tx.size() > 0) ? got_tx[0] : 8'hxx, 8'hC9);
    check_eq("c9_echo_delay", (txs_cyc.size() > 0 && rv_cyc.size() > 0) ? txs_cyc[0] - rv_cyc[0] : -1, 1);
    check_eq("c9_busy_len", (busy_len.size() > 0) ? busy_len[0] : -1, 10);

    // Framing error, then the line is held low: nothing may be accepted.
    clear_logs();
    send_a(8'h55, 1'b0);
    repeat (12) begin @(negedge clk); rx_a = 1'b0; end
    idle_a(20);
    check_eq("ferr_count", n_fe, 1);
    check_eq("ferr_no_valid", got_rx.size(), 0);
    check_eq("ferr_data_kept", rxd_a, 8'hC9);
    check_eq("ferr_no_tx", got_tx.size(), 0);
    r = 8'($urandom);
    send_a(r, 1'b1);
    idle_a(20);
    check_eq("ferr_recover_count", got_rx.size(), 1);
    check_eq("ferr_recover_byte", rxd_a, r);

    // Back-to-back frames: the second echo is dropped.
    clear_logs();
    send_a(8'hA5, 1'b1);
    send_a(8'h3C, 1'b1);
    idle_a(25);
    check_eq("ovr_rx_count", got_rx.size(), 2);
    check_eq("ovr_rx_data", rxd_a, 8'h3C);
    check_eq("ovr_pulses", n_ovr, 1);
    check_eq("ovr_tx_count", got_tx.size(), 1);
    check_eq("ovr_tx_byte", (got_tx.size() > 0) ? got_tx[0] : 8'hxx, 8'hA5);

    // Reset pulse while the echo of 8'h96 is on bit 3 (a 0 on the line).
    clear_logs();
    send_a(8'h96, 1'b1);
    idle_a(7);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("mrst_tx_bit",   tx_a,    1);
    check_eq("mrst_tx_ready", trdy_a,  1);
    check_eq("mrst_tx_busy",  tbusy_a, 0);
    check_eq("mrst_rx_valid", rv_a,    0);
    check_eq("mrst_rx_data",  rxd_a,   0);
    #4 rst = 1'b0;
    idle_a(12);
    check_eq("mrst_no_tx", got_tx.size(), 0);
    r = 8'($urandom);
    clear_logs();
    send_a(r, 1'b1);
    idle_a(20);
    check_eq("mrst_rx_after", rxd_a, r);
    check_eq("mrst_tx_after", (got_tx.size() > 0) ? got_tx[0] : 8'hxx, r);

    // Random frames with random idle gaps; echo dropped whenever TX is still busy.
    clear_logs();
    t = 0; last_acc = -100; exp_ovr = 0;
    for (int i = 0; i < 30; i++) begin
      b   = 8'($urandom);
      gap = $urandom_range(0, 2);
      exp_rx.push_back(b);
      rvt = t + 9 + 3;
      if (rvt >= last_acc + 11) begin
        exp_tx.push_back(b);
        last_acc = rvt;
      end else begin
        exp_ovr++;
      end
      send_a(b, 1'b1);
      idle_a(gap);
      t += 10 + gap;
    end
    idle_a(30);
    check_eq("rnd_rx_count", got_rx.size(), exp_rx.size());
    check_eq("rnd_tx_count", got_tx.size(), exp_tx.size());
    check_eq("rnd_overruns", n_ovr, exp_ovr);
    check_eq("rnd_frame_err", n_fe, 0);
    for (int i = 0; i < exp_rx.size(); i++)
      check_eq($sformatf("rnd_rx_%0d", i), (i < got_rx.size()) ? got_rx[i] : 8'hxx, exp_rx[i]);
    for (int i = 0; i < exp_tx.size(); i++)
      check_eq($sformatf("rnd_tx_%0d", i), (i < got_tx.size()) ? got_tx[i] : 8'hxx, exp_tx[i]);

    // Instance B: false start (low for 4 of 16 clocks).
    n_rv_b = 0; n_fe_b = 0;
    repeat (4) begin @(negedge clk); rx_b = 1'b0; end
    repeat (60) begin @(negedge clk); rx_b = 1'b1; end
    check_eq("fs_no_valid", n_rv_b, 0);
    check_eq("fs_no_ferr", n_fe_b, 0);
    r = 8'($urandom);
    send_b(r);
    repeat (60) begin @(negedge clk); rx_b = 1'b1; end
    check_eq("b_rx_count", n_rv_b, 1);
    check_eq("b_rx_data", rxd_b, r);
    check_eq("b_frame_err", n_fe_b, 0);

    // Instance B transmitter: sample the middle of each 16-clock bit.
    r  = 8'($urandom);
    fr = {1'b1, r, 1'b0};
    check_eq("b_tx_ready_idle", trdy_b, 1);
    @(negedge clk); tv_b = 1'b1; txd_b = r;
    @(negedge clk); tv_b = 1'b0;
    repeat (8) @(negedge clk);
    check_eq("b_tx_busy", tbusy_b, 1);
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("b_tx_bit_%0d", i), tx_b, fr[i]);
      if (i < 9) repeat (16) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check_eq("b_tx_ready_end", trdy_b, 1);
    check_eq("b_tx_line_idle", tx_b, 1);
    check_eq("b_no_overrun", n_ovr_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
